clk_div_multi: RTL and testbench
================================

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CW, default 32, width of each channel's counter and divisor.
REQ-003 Parameter DEFAULT_DIV, default 200_000_000, divisor loaded into every channel at reset.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  NCH  per-channel count enable.
REQ-007 sync_all  input  1  one-cycle pulse; phase-aligns all channels.
REQ-008 wr_en  input  1  divisor write strobe.
REQ-009 wr_ch  input  4  target channel index for the write.
REQ-010 wr_div  input  CW  new divisor value.
REQ-011 wr_mode  input  1  new channel mode: 0 = toggle (square wave), 1 = pulse.
REQ-012 clk_out  output  NCH  per-channel divided output level, registered.
REQ-013 tick  output  NCH  per-channel one-cycle terminal-count strobe, registered.

Function
REQ-014 Each channel shall hold a counter cnt[CW-1:0], divisor div[CW-1:0] and mode bit.
REQ-015 With en[i]=1, cnt increments by 1 per cycle while cnt < div; when cnt == div, cnt returns to 0 on the next edge (terminal count).
REQ-016 At terminal count, tick[i] shall be 1 for exactly the following cycle; otherwise tick[i] = 0.
REQ-017 Toggle mode: clk_out[i] inverts at each terminal count, giving a period of 2*(div+1) clk cycles and 50% duty.
REQ-018 Pulse mode: clk_out[i] equals tick[i], giving a period of (div+1) cycles.
REQ-019 div = 0 is legal: toggle mode inverts every cycle (clk/2); pulse mode holds clk_out high continuously.
REQ-020 With en[i]=0, cnt and clk_out[i] hold their values, and tick[i] = 0.
REQ-021 A write with wr_en=1 and wr_ch < NCH loads div and mode, clears cnt to 0, and forces tick to 0 on the next cycle.
REQ-022 A write leaves the clk_out level unchanged in toggle mode.
REQ-023 A write with wr_ch >= NCH shall be ignored with no state change.
REQ-024 sync_all=1 clears cnt and clk_out for all channels to 0 and forces tick to 0, regardless of en.
REQ-025 When sync_all and wr_en occur in the same cycle, the divisor and mode write still lands and the counters and outputs follow sync_all.
REQ-026 Counters shall never exceed div; arithmetic is unsigned CW-bit with no wrap past div.

Reset
REQ-027 On rst=1 at a clock edge: every cnt = 0, div = DEFAULT_DIV, mode = 0, clk_out = 0 and tick = 0.
REQ-028 rst takes priority over sync_all, wr_en and en.
REQ-029 Reset asserted mid-count shall abandon the count, with no tick generated.
REQ-030 The first terminal count after reset release occurs DEFAULT_DIV+1 enabled cycles later.

Structure
REQ-031 Package clk_div_pkg holds the CW default, DEFAULT_DIV, the mode encodings (MODE_TOGGLE = 0, MODE_PULSE = 1) and the channel-index width.
REQ-032 One sub-module, clk_div_chan, implements a single channel (cnt, div, mode, clk_out, tick).
REQ-033 clk_div_multi instantiates clk_div_chan NCH times via generate, plus the write-decode and broadcast logic.

Verification
REQ-034 Reset test: NCH=4, DEFAULT_DIV=3, en=4'hF after rst -> each clk_out toggles every 4 cycles, and tick pulses on cycles 4, 8, 12 after release.
REQ-035 Write test: write ch2 div=0 mode=0 -> clk_out[2] toggles every cycle; then write ch2 div=5 mode=1 -> tick[2] = clk_out[2], pulsing every 6 cycles.
REQ-036 Enable test: drop en[1] for 10 cycles mid-count at cnt=2 -> cnt[1] holds at 2 and no tick[1]; on re-enable, tick[1] arrives after 2 more cycles (div=3).
REQ-037 Align test: channels with div=3,5,7 run freely; pulse sync_all -> all clk_out = 0 next cycle, and first toggles occur 4, 6 and 8 cycles later.
REQ-038 Collision test: write to wr_ch=9 with NCH=4 -> no change on any channel; sync_all and a write to ch0 in the same cycle -> ch0 takes the new div with cnt=0 and clk_out=0.
REQ-039 Mid-reset test: assert rst at cnt=2 of div=3 -> no tick, all outputs 0, and counting restarts from DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and types for the multi-channel clock divider.
//   CW_DEF          default counter/divisor width
//   DEFAULT_DIV_DEF default divisor loaded at reset
//   mode_e          channel output mode (toggle / pulse)
//   CH_IDX_W        width of the write channel index
package clk_div_pkg;

    localparam int          CW_DEF          = 32;
    localparam int unsigned DEFAULT_DIV_DEF = 200_000_000;
    localparam int          CH_IDX_W        = 4;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel (counter, divisor, mode, output level, tick).
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_en       count enable
//   i_sync     phase-align: clear counter and outputs
//   i_wr       load i_wr_div / i_wr_mode into this channel
//   i_wr_div   new divisor
//   i_wr_mode  new mode (0 toggle, 1 pulse)
//   o_clk_out  divided output level
//   o_tick     one-cycle terminal-count strobe
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          CW          = CW_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_sync,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wr_div,
    input  logic          i_wr_mode,
    output logic          o_clk_out,
    output logic          o_tick
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    mode_e         r_mode;
    logic          r_clk_out;
    logic          r_tick;

    // >= rather than == so the counter can never run past the divisor
    logic w_tc;
    assign w_tc = (r_cnt >= r_div);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_div     <= CW'(DEFAULT_DIV);
            r_mode    <= MODE_TOGGLE;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            // Divisor/mode load is independent of sync so a colliding write still lands
            if (i_wr) begin
                r_div  <= i_wr_div;
                r_mode <= mode_e'(i_wr_mode);
            end
            if (i_sync) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else if (i_wr) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
                // Toggle keeps its level; pulse output mirrors the (cleared) tick
                if (mode_e'(i_wr_mode) == MODE_PULSE)
                    r_clk_out <= 1'b0;
            end else if (i_en) begin
                if (w_tc) begin
                    r_cnt     <= '0;
                    r_tick    <= 1'b1;
                    r_clk_out <= (r_mode == MODE_TOGGLE) ? ~r_clk_out : 1'b1;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_tick <= 1'b0;
                    if (r_mode == MODE_PULSE)
                        r_clk_out <= 1'b0;
                end
            end else begin
                // Counter and toggle level hold; a pulse output stays equal to tick
                r_tick <= 1'b0;
                if (r_mode == MODE_PULSE)
                    r_clk_out <= 1'b0;
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent programmable clock dividers with broadcast align.
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_en        per-channel count enable
//   i_sync_all  one-cycle pulse, phase-aligns all channels
//   i_wr_en     divisor write strobe
//   i_wr_ch     target channel (ignored when >= NCH)
//   i_wr_div    new divisor
//   i_wr_mode   new mode (0 toggle, 1 pulse)
//   o_clk_out   per-channel divided level
//   o_tick      per-channel terminal-count strobe
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          CW          = CW_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NCH-1:0]      i_en,
    input  logic                i_sync_all,
    input  logic                i_wr_en,
    input  logic [CH_IDX_W-1:0] i_wr_ch,
    input  logic [CW-1:0]       i_wr_div,
    input  logic                i_wr_mode,
    output logic [NCH-1:0]      o_clk_out,
    output logic [NCH-1:0]      o_tick
);

    // Only indices below NCH decode, so out-of-range writes touch nothing
    logic [NCH-1:0] w_wr_hit;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_wr_hit[i] = i_wr_en && (i_wr_ch == CH_IDX_W'(i));

        clk_div_chan #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_en[i]),
            .i_sync    (i_sync_all),
            .i_wr      (w_wr_hit[i]),
            .i_wr_div  (i_wr_div),
            .i_wr_mode (i_wr_mode),
            .o_clk_out (o_clk_out[i]),
            .o_tick    (o_tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int DD  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  en = '0;
    logic            sync_all = 1'b0;
    logic            wr_en = 1'b0;
    logic [3:0]      wr_ch = '0;
    logic [CW-1:0]   wr_div = '0;
    logic            wr_mode = 1'b0;
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  tick;

    int vecs = 0;
    int errs = 0;

    clk_div_multi #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DD)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_sync_all (sync_all),
        .i_wr_en    (wr_en),
        .i_wr_ch    (wr_ch),
        .i_wr_div   (wr_div),
        .i_wr_mode  (wr_mode),
        .o_clk_out  (clk_out),
        .o_tick     (tick)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sync_all = 1'b0; wr_en = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [CW-1:0] d, input logic m);
        wr_en = 1'b1; wr_ch = ch; wr_div = d; wr_mode = m;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [NCH-1:0] e_co, e_tk;
        en = 4'hF;
        do_reset();
        vecs++;
        if (clk_out !== 4'h0 || tick !== 4'h0) begin
            errs++;
            $display("FAIL reset_state clk_out=%h tick=%h required 0/0", clk_out, tick);
        end
        for (int c = 1; c <= 12; c++) begin
            cyc();
            e_tk = (c % 4 == 0) ? 4'hF : 4'h0;
            e_co = ((c / 4) % 2 == 1) ? 4'hF : 4'h0;
            vecs++;
            if (clk_out !== e_co || tick !== e_tk) begin
                errs++;
                $display("FAIL reset_run c=%0d clk_out=%h tick=%h required %h/%h", c, clk_out, tick, e_co, e_tk);
            end
        end
    endtask

    task automatic test_write();
        logic e;
        // ch2 level is 1 here (toggled at cycles 4, 8, 12)
        wr(4'd2, 32'd0, 1'b0);
        vecs++;
        if (clk_out[2] !== 1'b1 || tick[2] !== 1'b0) begin
            errs++;
            $display("FAIL write_div0_load clk_out2=%b tick2=%b required 1/0", clk_out[2], tick[2]);
        end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            e = (k % 2 == 1) ? 1'b0 : 1'b1;
            vecs++;
            if (clk_out[2] !== e || tick[2] !== 1'b1) begin
                errs++;
                $display("FAIL write_div0 k=%0d clk_out2=%b tick2=%b required %b/1", k, clk_out[2], tick[2], e);
            end
        end
        wr(4'd2, 32'd5, 1'b1);
        vecs++;
        if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
            errs++;
            $display("FAIL write_pulse_load clk_out2=%b tick2=%b required 0/0", clk_out[2], tick[2]);
        end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            e = (k % 6 == 0);
            vecs++;
            if (clk_out[2] !== e || tick[2] !== e) begin
                errs++;
                $display("FAIL write_pulse k=%0d clk_out2=%b tick2=%b required %b/%b", k, clk_out[2], tick[2], e, e);
            end
        end
    endtask

    task automatic test_enable();
        en = 4'hF;
        do_reset();
        cyc(); cyc();          // cnt = 2 on every channel
        en = 4'b1101;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            vecs++;
            if (tick[1] !== 1'b0 || clk_out[1] !== 1'b0) begin
                errs++;
                $display("FAIL enable_hold k=%0d tick1=%b clk_out1=%b required 0/0", k, tick[1], clk_out[1]);
            end
        end
        en = 4'hF;
        cyc();
        vecs++;
        if (tick[1] !== 1'b0) begin
            errs++;
            $display("FAIL enable_resume1 tick1=%b required 0", tick[1]);
        end
        cyc();
        vecs++;
        if (tick[1] !== 1'b1 || clk_out[1] !== 1'b1) begin
            errs++;
            $display("FAIL enable_resume2 tick1=%b clk_out1=%b required 1/1", tick[1], clk_out[1]);
        end
    endtask

    // Channels: 0 div3, 1 div5, 2 div7, 3 default div3, all toggle
    task automatic check_aligned(input string nm);
        logic [NCH-1:0] e_co, e_tk;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            wr_en = 1'b0;
            e_co = {1'((k / 4) % 2), 1'((k / 8) % 2), 1'((k / 6) % 2), 1'((k / 4) % 2)};
            e_tk = {k % 4 == 0, k % 8 == 0, k % 6 == 0, k % 4 == 0};
            vecs++;
            if (clk_out !== e_co || tick !== e_tk) begin
                errs++;
                $display("FAIL %s k=%0d clk_out=%h tick=%h required %h/%h", nm, k, clk_out, tick, e_co, e_tk);
            end
        end
    endtask

    task automatic test_align();
        en = 4'hF;
        do_reset();
        wr(4'd0, 32'd3, 1'b0);
        wr(4'd1, 32'd5, 1'b0);
        wr(4'd2, 32'd7, 1'b0);
        for (int k = 0; k < 9; k++) cyc();
        sync_all = 1'b1;
        cyc();
        sync_all = 1'b0;
        vecs++;
        if (clk_out !== 4'h0 || tick !== 4'h0) begin
            errs++;
            $display("FAIL align_sync clk_out=%h tick=%h required 0/0", clk_out, tick);
        end
        check_aligned("align_run");
    endtask

    task automatic test_collision();
        sync_all = 1'b1;
        cyc();
        sync_all = 1'b0;
        // Out-of-range write during the first aligned cycle must not disturb anything
        wr_en = 1'b1; wr_ch = 4'd9; wr_div = 32'd0; wr_mode = 1'b1;
        check_aligned("collide_badch");
        sync_all = 1'b1;
        wr_en = 1'b1; wr_ch = 4'd0; wr_div = 32'd2; wr_mode = 1'b0;
        cyc();
        sync_all = 1'b0; wr_en = 1'b0;
        vecs++;
        if (clk_out !== 4'h0 || tick !== 4'h0) begin
            errs++;
            $display("FAIL collide_sync clk_out=%h tick=%h required 0/0", clk_out, tick);
        end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            vecs++;
            if (clk_out[0] !== 1'((k / 3) % 2) || tick[0] !== (k % 3 == 0)) begin
                errs++;
                $display("FAIL collide_ch0 k=%0d clk_out0=%b tick0=%b required %b/%b",
                         k, clk_out[0], tick[0], 1'((k / 3) % 2), (k % 3 == 0));
            end
        end
    endtask

    task automatic test_midreset();
        logic [NCH-1:0] e;
        en = 4'hF;
        wr(4'd0, 32'd9, 1'b1);     // reset must restore div and mode too
        do_reset();
        cyc(); cyc();              // cnt = 2
        rst = 1'b1;
        cyc();
        vecs++;
        if (clk_out !== 4'h0 || tick !== 4'h0) begin
            errs++;
            $display("FAIL midreset_state clk_out=%h tick=%h required 0/0", clk_out, tick);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            e = (k == 4) ? 4'hF : 4'h0;
            vecs++;
            if (clk_out !== e || tick !== e) begin
                errs++;
                $display("FAIL midreset_run k=%0d clk_out=%h tick=%h required %h/%h", k, clk_out, tick, e, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout vecs=%0d required completion", vecs);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_enable();
        test_align();
        test_collision();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
